controle_hazard_pipeline: RTL and testbench
===========================================

// Module: controle_hazard_pipeline
// PURPOSE
// Hazard and stall controller for the 5-stage MIPS32 pipeline (IF, ID, EX, MEM, WB).
// Drives the parada/limpar inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB RegPipeline instances.
// Covers four cases: load-use hazard, taken branch/jump flush, multi-cycle MULT/DIV occupancy, and data-memory/UART wait states.
// Includes a memory-wait timeout and a saturating stall-cycle counter.
// PARAMETERS
// MD_LAT      32  cycles a MULT/DIV occupies the HI/LO unit, counted from its issue cycle in EX (>=2)
// MEM_TIMEOUT 255 max consecutive memory wait cycles before forced release (>=1)
// CNT_W       16  width of ciclos_parada
// PORTS
// clock          in  1     rising-edge clock
// reset          in  1     asynchronous, active-high
// id_rs          in  5     rs of instruction in ID
// id_rt          in  5     rt of instruction in ID
// id_usa_hilo    in  1     ID instruction is MFHI/MFLO/MULT/DIV
// ex_le_mem      in  1     EX instruction is a load
// ex_rt          in  5     destination register of the load in EX
// ex_desvio      in  1     branch/jump resolved taken in EX
// ex_muldiv      in  1     MULT/DIV issuing in EX this cycle
// mem_req        in  1     MEM stage is accessing memory
// mem_pronto     in  1     memory/UART completes the access this cycle
// parada_pc      out 1     hold PC
// parada_ifid    out 1     hold IF/ID
// limpar_ifid    out 1     clear IF/ID
// parada_idex    out 1     hold ID/EX
// limpar_idex    out 1     clear ID/EX (bubble)
// parada_exmem   out 1     hold EX/MEM
// limpar_memwb   out 1     clear MEM/WB (bubble)
// muldiv_ocupado out 1     HI/LO unit busy (md_cnt != 0)
// erro_mem       out 1     sticky: a memory timeout occurred
// ciclos_parada  out CNT_W count of cycles with parada_pc=1, saturating at all-ones
// BEHAVIOUR
// - Reset (async): state=RUN; md_cnt=0, wait_cnt=0, erro_mem=0, ciclos_parada=0.
//   All control outputs are 0 while reset is high.
// - Control outputs are combinational from inputs and registered state.
//   They act at the next rising edge through RegPipeline.
// - FSM RUN: mem_req & ~mem_pronto -> MEM_WAIT; wait_cnt=1.
// - FSM MEM_WAIT:
//   - mem_pronto -> RUN.
//   - Otherwise wait_cnt++.
//   - wait_cnt==MEM_TIMEOUT -> RUN, set erro_mem, treat this cycle as completed (no stall).
//   - mem_req dropping -> RUN.
// - mem_stall = mem_req & ~mem_pronto & ~(timeout cycle).
//   - Raises parada_pc, parada_ifid, parada_idex, parada_exmem, limpar_memwb.
//   - Forces all other outputs to 0. Highest priority.
// - Branch (ex_desvio & ~mem_stall): limpar_ifid=1, limpar_idex=1, no paradas.
//   - Overrides load-use and HI/LO hazards, since the ID instruction is wrong-path.
// - Load-use (~mem_stall & ~ex_desvio): condition is ex_le_mem & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
//   - Raises parada_pc, parada_ifid, limpar_idex. Exactly one bubble.
// - HI/LO hazard (~mem_stall & ~ex_desvio): condition is muldiv_ocupado & id_usa_hilo.
//   - Same outputs as load-use; repeats each cycle until md_cnt reaches 0.
// - md_cnt:
//   - ex_muldiv & ~mem_stall loads MD_LAT-1.
//   - Otherwise decrements when nonzero, including during mem_stall (the unit runs freely).
//   - The issue guard above prevents a new MULT/DIV from entering EX while busy.
// - ciclos_parada: increments on every cycle with parada_pc=1; holds at 2^CNT_W-1.
// - erro_mem: cleared only by reset.
// - Reset mid-stall: all outputs drop immediately; md_cnt, wait_cnt and FSM are cleared.
// TESTING
// - Load-use: ex_le_mem=1, ex_rt=5, id_rs=5.
//   -> one cycle of parada_pc=parada_ifid=limpar_idex=1; ciclos_parada=1.
// - ex_rt=0 with id_rs=0 and ex_le_mem=1 -> no stall.
//   Same hazard with ex_desvio=1 -> limpar_ifid=limpar_idex=1 and parada_pc=0.
// - MD_LAT=4: ex_muldiv at cycle 0 and id_usa_hilo=1 from cycle 1.
//   -> stall during cycles 1-3; released at cycle 4; muldiv_ocupado 1 during cycles 1-3.
// - mem_req=1, mem_pronto low for 3 cycles -> all paradas plus limpar_memwb for 3 cycles.
//   ex_desvio during the wait is ignored; branch flush happens on the release cycle.
// - MEM_TIMEOUT=4, mem_pronto never asserted.
//   -> stall for exactly 3 cycles; erro_mem=1 on the 4th; erro_mem stays 1 until reset.
// - Assert reset during the HI/LO stall -> outputs 0 at once; after release md_cnt=0, erro_mem=0, ciclos_parada=0.

Source files
------------

// File: rtl/controle_hazard_pipeline_if.sv
// Control bundle between the MIPS32 datapath and the hazard controller.
// The datapath side is the master: it reports ID/EX/MEM status and receives hold/clear strobes.
interface controle_hazard_pipeline_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_usa_hilo;
    logic             ex_le_mem;
    logic [4:0]       ex_rt;
    logic             ex_desvio;
    logic             ex_muldiv;
    logic             mem_req;
    logic             mem_pronto;

    logic             parada_pc;
    logic             parada_ifid;
    logic             limpar_ifid;
    logic             parada_idex;
    logic             limpar_idex;
    logic             parada_exmem;
    logic             limpar_memwb;
    logic             muldiv_ocupado;
    logic             erro_mem;
    logic [CNT_W-1:0] ciclos_parada;

    modport master (
        output id_rs, id_rt, id_usa_hilo, ex_le_mem, ex_rt, ex_desvio,
               ex_muldiv, mem_req, mem_pronto,
        input  parada_pc, parada_ifid, limpar_ifid, parada_idex, limpar_idex,
               parada_exmem, limpar_memwb, muldiv_ocupado, erro_mem, ciclos_parada
    );

    modport slave (
        input  id_rs, id_rt, id_usa_hilo, ex_le_mem, ex_rt, ex_desvio,
               ex_muldiv, mem_req, mem_pronto,
        output parada_pc, parada_ifid, limpar_ifid, parada_idex, limpar_idex,
               parada_exmem, limpar_memwb, muldiv_ocupado, erro_mem, ciclos_parada
    );
endinterface

// File: rtl/controle_hazard_pipeline.sv
// Hazard/stall controller for the 5-stage MIPS32 pipeline: load-use, branch flush,
// MULT/DIV occupancy and memory wait states, with a memory timeout and stall counter.
module controle_hazard_pipeline #(
    parameter int MD_LAT      = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic clock,
    input  logic reset,
    controle_hazard_pipeline_if.slave bus
);
    localparam int MD_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state_reg, state_next;
    logic [WT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [MD_W-1:0]  md_cnt_reg, md_cnt_next;
    logic             erro_reg, erro_next;
    logic [CNT_W-1:0] ciclos_reg, ciclos_next;

    logic [WT_W-1:0]  cur_wait;
    logic             mem_miss;
    logic             timeout;
    logic             mem_stall;
    logic             load_use;
    logic             hilo_hazard;
    logic             md_busy;

    logic parada_pc, parada_ifid, limpar_ifid, parada_idex;
    logic limpar_idex, parada_exmem, limpar_memwb;

    // cur_wait is the ordinal of the current miss cycle within the ongoing wait
    always_comb begin
        cur_wait    = (state_reg == MEM_WAIT) ? wait_cnt_reg + WT_W'(1) : WT_W'(1);
        mem_miss    = bus.mem_req & ~bus.mem_pronto;
        timeout     = mem_miss & (cur_wait == WT_W'(MEM_TIMEOUT));
        mem_stall   = mem_miss & ~timeout;
        md_busy     = (md_cnt_reg != '0);
        load_use    = bus.ex_le_mem & (bus.ex_rt != 5'd0) &
                      ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
        hilo_hazard = md_busy & bus.id_usa_hilo;
    end

    // Priority: memory wait > taken branch > load-use / HI/LO interlock
    always_comb begin
        parada_pc    = 1'b0;
        parada_ifid  = 1'b0;
        limpar_ifid  = 1'b0;
        parada_idex  = 1'b0;
        limpar_idex  = 1'b0;
        parada_exmem = 1'b0;
        limpar_memwb = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                parada_pc    = 1'b1;
                parada_ifid  = 1'b1;
                parada_idex  = 1'b1;
                parada_exmem = 1'b1;
                limpar_memwb = 1'b1;
            end else if (bus.ex_desvio) begin
                limpar_ifid = 1'b1;
                limpar_idex = 1'b1;
            end else if (load_use | hilo_hazard) begin
                parada_pc   = 1'b1;
                parada_ifid = 1'b1;
                limpar_idex = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                wait_cnt_next = '0;
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = cur_wait;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // The HI/LO unit keeps counting through memory stalls; only a new issue is held off
    always_comb begin
        md_cnt_next = md_cnt_reg;
        if (bus.ex_muldiv && !mem_stall) begin
            md_cnt_next = MD_W'(MD_LAT - 1);
        end else if (md_busy) begin
            md_cnt_next = md_cnt_reg - MD_W'(1);
        end
    end

    always_comb begin
        erro_next   = erro_reg | timeout;
        ciclos_next = ciclos_reg;
        if (parada_pc && (ciclos_reg != {CNT_W{1'b1}})) begin
            ciclos_next = ciclos_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            md_cnt_reg   <= '0;
            erro_reg     <= 1'b0;
            ciclos_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            md_cnt_reg   <= md_cnt_next;
            erro_reg     <= erro_next;
            ciclos_reg   <= ciclos_next;
        end
    end

    assign bus.parada_pc      = parada_pc;
    assign bus.parada_ifid    = parada_ifid;
    assign bus.limpar_ifid    = limpar_ifid;
    assign bus.parada_idex    = parada_idex;
    assign bus.limpar_idex    = limpar_idex;
    assign bus.parada_exmem   = parada_exmem;
    assign bus.limpar_memwb   = limpar_memwb;
    assign bus.muldiv_ocupado = md_busy & ~reset;
    // The timeout cycle already reports the error, before the sticky flag is written
    assign bus.erro_mem       = (erro_reg | timeout) & ~reset;
    assign bus.ciclos_parada  = ciclos_reg;
endmodule

// File: tb/tb_controle_hazard_pipeline.sv
// Scoreboard bench for controle_hazard_pipeline: directed cases then randomized traffic,
// each cycle checked against a cycle-numbered behavioural model.
module tb_controle_hazard_pipeline;
    localparam int MD_LAT      = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CW          = 6;
    localparam int CMAX        = (1 << CW) - 1;

    localparam logic [8:0] C_LU = 9'b110010000;
    localparam logic [8:0] C_BR = 9'b001010000;
    localparam logic [8:0] C_MS = 9'b110101100;

    logic clock;
    logic reset;

    controle_hazard_pipeline_if #(.CNT_W(CW)) bus ();

    controle_hazard_pipeline #(
        .MD_LAT(MD_LAT),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usa_hilo;
        logic       le_mem;
        logic [4:0] ex_rt;
        logic       desvio;
        logic       muldiv;
        logic       mem_req;
        logic       mem_pronto;
    } stim_t;

    typedef struct {
        logic [8:0] ctrl;
        int         cic;
        bit         dchk;
        logic [8:0] dctrl;
        int         dcic;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: absolute cycle numbers and plain counters
    int cyc          = 0;
    int busy_until   = 0;
    int miss_run     = 0;
    bit erro_seen    = 0;
    int stall_cycles = 0;

    task automatic step(input stim_t s, input bit dchk, input logic [8:0] dctrl,
                        input int dcic, input string tag);
        exp_t e;
        bit   miss, tout, stall, busy, hazard;
        int   run;
        logic [8:0] c;
        @(posedge clock);
        #1;
        reset           = s.rst;
        bus.id_rs       = s.rs;
        bus.id_rt       = s.rt;
        bus.id_usa_hilo = s.usa_hilo;
        bus.ex_le_mem   = s.le_mem;
        bus.ex_rt       = s.ex_rt;
        bus.ex_desvio   = s.desvio;
        bus.ex_muldiv   = s.muldiv;
        bus.mem_req     = s.mem_req;
        bus.mem_pronto  = s.mem_pronto;
        cyc++;
        c = '0;
        if (s.rst) begin
            busy_until   = 0;
            miss_run     = 0;
            erro_seen    = 0;
            stall_cycles = 0;
            e.cic        = 0;
        end else begin
            miss   = s.mem_req && !s.mem_pronto;
            run    = miss ? miss_run + 1 : 0;
            tout   = miss && (run == MEM_TIMEOUT);
            stall  = miss && !tout;
            busy   = cyc < busy_until;
            hazard = (s.le_mem && s.ex_rt != 0 && (s.ex_rt == s.rs || s.ex_rt == s.rt))
                     || (busy && s.usa_hilo);
            if (stall)         c[8:2] = C_MS[8:2];
            else if (s.desvio) c[8:2] = C_BR[8:2];
            else if (hazard)   c[8:2] = C_LU[8:2];
            c[1] = busy;
            c[0] = erro_seen || tout;
            e.cic = (stall_cycles > CMAX) ? CMAX : stall_cycles;
            stall_cycles += int'(c[8]);
            if (s.muldiv && !stall) busy_until = cyc + MD_LAT;
            miss_run = stall ? run : 0;
            if (tout) erro_seen = 1;
        end
        e.ctrl  = c;
        e.dchk  = dchk;
        e.dctrl = dctrl;
        e.dcic  = dcic;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic dstep(input stim_t s, input logic [8:0] dctrl, input int dcic,
                         input string tag);
        step(s, 1'b1, dctrl, dcic, tag);
    endtask

    // Monitor: the controller presents a full output word every cycle
    initial begin
        exp_t e;
        logic [8:0] act;
        int         acic;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {bus.parada_pc, bus.parada_ifid, bus.limpar_ifid, bus.parada_idex,
                       bus.limpar_idex, bus.parada_exmem, bus.limpar_memwb,
                       bus.muldiv_ocupado, bus.erro_mem};
                acic = int'(bus.ciclos_parada);
                n_cmp++;
                if (act !== e.ctrl) begin
                    n_bad++;
                    $display("FAIL model_ctrl %s t=%0t got=%b want=%b", e.tag, $time, act, e.ctrl);
                end
                n_cmp++;
                if (acic != e.cic) begin
                    n_bad++;
                    $display("FAIL model_ciclos %s t=%0t got=%0d want=%0d", e.tag, $time, acic, e.cic);
                end
                if (e.dchk) begin
                    n_cmp++;
                    if (act !== e.dctrl) begin
                        n_bad++;
                        $display("FAIL dir_ctrl %s got=%b want=%b", e.tag, act, e.dctrl);
                    end
                    n_cmp++;
                    if (acic != e.dcic) begin
                        n_bad++;
                        $display("FAIL dir_ciclos %s got=%0d want=%0d", e.tag, acic, e.dcic);
                    end
                    $display("txn %-12s ctrl=%b ciclos=%0d", e.tag, act, acic);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        reset           = 1'b1;
        bus.id_rs       = '0;
        bus.id_rt       = '0;
        bus.id_usa_hilo = 1'b0;
        bus.ex_le_mem   = 1'b0;
        bus.ex_rt       = '0;
        bus.ex_desvio   = 1'b0;
        bus.ex_muldiv   = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_pronto  = 1'b0;

        s = '0; s.rst = 1'b1;
        dstep(s, '0, 0, "reset0");
        dstep(s, '0, 0, "reset1");

        s = '0; s.le_mem = 1; s.ex_rt = 5; s.rs = 5;
        dstep(s, C_LU, 0, "load_use");
        s = '0;
        dstep(s, '0, 1, "lu_after");

        s = '0; s.le_mem = 1; s.ex_rt = 0; s.rs = 0;
        dstep(s, '0, 1, "rt_zero");
        s.le_mem = 1; s.ex_rt = 5; s.rs = 5; s.desvio = 1;
        dstep(s, C_BR, 1, "lu_branch");

        s = '0; s.muldiv = 1;
        dstep(s, '0, 1, "md_issue");
        s = '0; s.usa_hilo = 1;
        dstep(s, C_LU | 9'b10, 1, "hilo_c1");
        dstep(s, C_LU | 9'b10, 2, "hilo_c2");
        dstep(s, C_LU | 9'b10, 3, "hilo_c3");
        dstep(s, '0, 4, "hilo_free");

        s = '0; s.mem_req = 1;
        dstep(s, C_MS, 4, "mwait1");
        s.desvio = 1;
        dstep(s, C_MS, 5, "mwait2_br");
        s.desvio = 0;
        dstep(s, C_MS, 6, "mwait3");
        s.mem_pronto = 1; s.desvio = 1;
        dstep(s, C_BR, 7, "mdone_br");
        s = '0;
        dstep(s, '0, 7, "idle");

        s = '0; s.mem_req = 1;
        dstep(s, C_MS, 7, "tmo1");
        dstep(s, C_MS, 8, "tmo2");
        dstep(s, C_MS, 9, "tmo3");
        dstep(s, 9'b1, 10, "tmo_fire");
        s = '0;
        dstep(s, 9'b1, 10, "erro_hold1");
        dstep(s, 9'b1, 10, "erro_hold2");

        s = '0; s.muldiv = 1;
        dstep(s, 9'b1, 10, "md_issue2");
        s = '0; s.usa_hilo = 1;
        dstep(s, C_LU | 9'b11, 10, "hilo_stall");
        s.rst = 1;
        dstep(s, '0, 0, "rst_mid");
        s.rst = 0;
        dstep(s, '0, 0, "rst_after");

        for (int i = 0; i < 4000; i++) begin
            s            = '0;
            s.rst        = ($urandom_range(0, 199) == 0);
            s.rs         = 5'($urandom_range(0, 5));
            s.rt         = 5'($urandom_range(0, 5));
            s.usa_hilo   = ($urandom_range(0, 2) == 0);
            s.le_mem     = ($urandom_range(0, 2) == 0);
            s.ex_rt      = 5'($urandom_range(0, 5));
            s.desvio     = ($urandom_range(0, 5) == 0);
            s.muldiv     = ($urandom_range(0, 7) == 0);
            s.mem_req    = ($urandom_range(0, 2) != 0);
            s.mem_pronto = ($urandom_range(0, 3) == 0);
            step(s, 1'b0, '0, 0, "rand");
        end

        s = '0;
        step(s, 1'b0, '0, 0, "drain");
        @(negedge clock);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
